// File: rtl/id_scoreboard_if.sv
// ID-stage hazard scoreboard port bundle: decoded ID fields and issue info in,
// stall/bubble and scoreboard status out.
interface id_scoreboard_if #(
   parameter int unsigned NREG = 32,
   parameter int unsigned RW   = 5,
   parameter int unsigned LW   = 3,
   parameter int unsigned SCW  = 16
);
   logic [RW-1:0]   id_rs;
   logic [RW-1:0]   id_rt;
   logic            id_use_rs;
   logic            id_use_rt;
   logic            issue_valid;
   logic            issue_we;
   logic [RW-1:0]   issue_rd;
   logic [LW-1:0]   issue_lat;
   logic            flush;
   logic            stall;
   logic            bubble;
   logic [NREG-1:0] busy_mask;
   logic [SCW-1:0]  stall_count;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
      output issue_valid, issue_we, issue_rd, issue_lat, flush,
      input  stall, bubble, busy_mask, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
      input  issue_valid, issue_we, issue_rd, issue_lat, flush,
      output stall, bubble, busy_mask, stall_count
   );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register pending-latency scoreboard for the ID stage: stalls/bubbles on
// RAW (and optionally WAW ordering) hazards and counts stalled cycles.
module id_scoreboard #(
   parameter int unsigned NREG      = 32,
   parameter int unsigned RW        = 5,
   parameter int unsigned MAX_LAT   = 4,
   parameter int unsigned LW        = 3,
   parameter int unsigned WAW_CHECK = 1,
   parameter int unsigned SCW       = 16
) (
   input logic           clk,
   input logic           rst_n,
   id_scoreboard_if.slave sb
);
   localparam logic [LW-1:0] MAX_LAT_L = LW'(MAX_LAT);
   localparam logic [RW-1:0] REG_ZERO  = '0;

   logic [LW-1:0]   cnt_q [NREG];
   logic [LW-1:0]   cnt_d [NREG];
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] busy_q;
   logic [SCW-1:0]  stall_count_q;
   logic [LW-1:0]   lat_eff;
   logic            raw;
   logic            waw;
   logic            stall_c;
   logic            accept;

   // Hazard detection against the pre-update counters
   always_comb begin
      lat_eff = (sb.issue_lat > MAX_LAT_L) ? MAX_LAT_L : sb.issue_lat;
      raw     = (sb.id_use_rs && (cnt_q[sb.id_rs] != '0)) ||
                (sb.id_use_rt && (cnt_q[sb.id_rt] != '0));
      waw     = (WAW_CHECK != 0) && sb.issue_we && (sb.issue_rd != REG_ZERO) &&
                (cnt_q[sb.issue_rd] > lat_eff);
      stall_c = sb.issue_valid && !sb.flush && (raw || waw);
      accept  = sb.issue_valid && !stall_c && !sb.flush && sb.issue_we &&
                (sb.issue_rd != REG_ZERO);
   end

   // Counter update: a fresh issue overrides the countdown; $0 never pends
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (accept && (sb.issue_rd == RW'(r))) begin
            cnt_d[r] = lat_eff;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - LW'(1);
         end
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q        <= '0;
         stall_count_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_q <= busy_d;
         // Saturating performance counter
         if (stall_c && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + SCW'(1);
         end
      end
   end

   assign sb.stall       = stall_c;
   assign sb.bubble      = stall_c;
   assign sb.busy_mask   = busy_q;
   assign sb.stall_count = stall_count_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: default config, WAW_CHECK=0 and SCW=2
// instances share one stimulus stream.
module tb_id_scoreboard;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   id_scoreboard_if #(.NREG(32), .RW(5), .LW(3), .SCW(16)) ifa ();
   id_scoreboard_if #(.NREG(32), .RW(5), .LW(3), .SCW(16)) ifb ();
   id_scoreboard_if #(.NREG(32), .RW(5), .LW(3), .SCW(2))  ifc ();

   id_scoreboard #(.NREG(32), .RW(5), .MAX_LAT(4), .LW(3), .WAW_CHECK(1), .SCW(16))
      dut_a (.clk(clk), .rst_n(rst_n), .sb(ifa));
   id_scoreboard #(.NREG(32), .RW(5), .MAX_LAT(4), .LW(3), .WAW_CHECK(0), .SCW(16))
      dut_b (.clk(clk), .rst_n(rst_n), .sb(ifb));
   id_scoreboard #(.NREG(32), .RW(5), .MAX_LAT(4), .LW(3), .WAW_CHECK(1), .SCW(2))
      dut_c (.clk(clk), .rst_n(rst_n), .sb(ifc));

   always #5 clk = ~clk;

   // Apply one ID-stage cycle of inputs to all instances at the falling edge
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] rd, input logic [2:0] lat, input logic fl);
      @(negedge clk);
      ifa.issue_valid = v;  ifb.issue_valid = v;  ifc.issue_valid = v;
      ifa.id_rs = rs;       ifb.id_rs = rs;       ifc.id_rs = rs;
      ifa.id_rt = rt;       ifb.id_rt = rt;       ifc.id_rt = rt;
      ifa.id_use_rs = urs;  ifb.id_use_rs = urs;  ifc.id_use_rs = urs;
      ifa.id_use_rt = urt;  ifb.id_use_rt = urt;  ifc.id_use_rt = urt;
      ifa.issue_we = we;    ifb.issue_we = we;    ifc.issue_we = we;
      ifa.issue_rd = rd;    ifb.issue_rd = rd;    ifc.issue_rd = rd;
      ifa.issue_lat = lat;  ifb.issue_lat = lat;  ifc.issue_lat = lat;
      ifa.flush = fl;       ifb.flush = fl;       ifc.flush = fl;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (ifa.stall !== 1'b0 || ifa.bubble !== 1'b0) $display("FAIL reset_stall: got %b/%b, expected 0/0", ifa.stall, ifa.bubble);
      else n_pass++;
      n_checks++;
      if (ifa.busy_mask !== 32'd0) $display("FAIL reset_busy: got %h, expected 0", ifa.busy_mask);
      else n_pass++;
      n_checks++;
      if (ifa.stall_count !== 16'd0 || ifc.stall_count !== 2'd0) $display("FAIL reset_count: got %0d/%0d, expected 0/0", ifa.stall_count, ifc.stall_count);
      else n_pass++;
   endtask

   task automatic test_lw_use();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 3'd1, 1'b0);
      n_checks++;
      if (ifa.stall !== 1'b0) $display("FAIL lw_issue_stall: got %b, expected 0", ifa.stall);
      else n_pass++;
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall !== 1'b1 || ifa.bubble !== 1'b1) $display("FAIL lw_use_stall: got %b/%b, expected 1/1", ifa.stall, ifa.bubble);
      else n_pass++;
      n_checks++;
      if (ifa.busy_mask !== 32'h0000_0100) $display("FAIL lw_use_busy: got %h, expected 00000100", ifa.busy_mask);
      else n_pass++;
      drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall !== 1'b0) $display("FAIL lw_use_release: got %b, expected 0", ifa.stall);
      else n_pass++;
      n_checks++;
      if (ifa.stall_count !== 16'd1) $display("FAIL lw_use_count: got %0d, expected 1", ifa.stall_count);
      else n_pass++;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      n_checks++;
      if (ifa.busy_mask !== 32'd0) $display("FAIL alu_busy: got %h, expected 0", ifa.busy_mask);
      else n_pass++;
   endtask

   task automatic test_multicycle();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 3'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic exp;
         exp = (i < 3);
         drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
         n_checks++;
         if (ifa.stall !== exp) $display("FAIL multi_stall[%0d]: got %b, expected %b", i, ifa.stall, exp);
         else n_pass++;
         n_checks++;
         if (ifa.busy_mask[10] !== exp) $display("FAIL multi_busy[%0d]: got %b, expected %b", i, ifa.busy_mask[10], exp);
         else n_pass++;
      end
   endtask

   task automatic test_reg0();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd1, 1'b0);
      drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall !== 1'b0) $display("FAIL reg0_stall: got %b, expected 0", ifa.stall);
      else n_pass++;
      n_checks++;
      if (ifa.busy_mask !== 32'd0) $display("FAIL reg0_busy: got %h, expected 0", ifa.busy_mask);
      else n_pass++;
   endtask

   task automatic test_waw();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         logic exp;
         exp = (i < 4);
         drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd0, 1'b0);
         n_checks++;
         if (ifa.stall !== exp) $display("FAIL waw_on[%0d]: got %b, expected %b", i, ifa.stall, exp);
         else n_pass++;
         n_checks++;
         if (ifb.stall !== 1'b0) $display("FAIL waw_off[%0d]: got %b, expected 0", i, ifb.stall);
         else n_pass++;
      end
   endtask

   task automatic test_clamp();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 3'd7, 1'b0);
      for (int i = 0; i < 5; i++) begin
         logic exp;
         exp = (i < 4);
         drive(1'b1, 5'd0, 5'd11, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
         n_checks++;
         if (ifa.stall !== exp) $display("FAIL clamp_stall[%0d]: got %b, expected %b", i, ifa.stall, exp);
         else n_pass++;
      end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 3'd1, 1'b1);
      drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall !== 1'b0) $display("FAIL flush_stall: got %b, expected 0", ifa.stall);
      else n_pass++;
      n_checks++;
      if (ifa.busy_mask !== 32'd0) $display("FAIL flush_busy: got %h, expected 0", ifa.busy_mask);
      else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 3'd3, 1'b0);
      drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall !== 1'b1 || ifa.stall_count !== 16'd1) $display("FAIL mid_pre: got stall %b count %0d, expected 1/1", ifa.stall, ifa.stall_count);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ifa.stall !== 1'b0 || ifa.busy_mask !== 32'd0 || ifa.stall_count !== 16'd0)
         $display("FAIL mid_reset: got stall %b busy %h count %0d, expected 0/0/0", ifa.stall, ifa.busy_mask, ifa.stall_count);
      else n_pass++;
   endtask

   task automatic test_saturate();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 3'd4, 1'b0);
      repeat (5) drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall_count !== 16'd4 || ifc.stall_count !== 2'd3) $display("FAIL sat_mid: got %0d/%0d, expected 4/3", ifa.stall_count, ifc.stall_count);
      else n_pass++;
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd14, 3'd2, 1'b0);
      repeat (2) drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
      n_checks++;
      if (ifa.stall_count !== 16'd6 || ifc.stall_count !== 2'd3) $display("FAIL sat_end: got %0d/%0d, expected 6/3", ifa.stall_count, ifc.stall_count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_lw_use();
      test_multicycle();
      test_reg0();
      test_waw();
      test_clamp();
      test_flush();
      test_reset_mid_stall();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
